// File: rtl/npc_mem_pkg.sv
// Shared types and defaults for the core's memory-port logic: bus owners,
// arbiter FSM states and default bus widths.
package npc_mem_pkg;

   localparam int ADDR_W_DEF = 64;
   localparam int DATA_W_DEF = 64;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch
// and the load/store unit; LS has priority, with a starvation guard for IF.
module mem_arbiter
   import npc_mem_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_LIM = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req_valid,
   output logic                if_req_ready,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_rsp_valid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                ls_req_valid,
   output logic                ls_req_ready,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic                ls_wen,
   input  logic [DATA_W-1:0]   ls_wdata,
   input  logic [DATA_W/8-1:0] ls_wmask,
   output logic                ls_rsp_valid,
   output logic [DATA_W-1:0]   ls_rdata,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_rsp_valid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int         MASK_W = DATA_W / 8;
   localparam logic [3:0] LIM    = 4'(STARVE_LIM);

   arb_state_e        state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [3:0]        starve_cnt_q, starve_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wen_q, wen_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [MASK_W-1:0] wmask_q, wmask_d;
   logic              ls_wins;

   // IF takes a tie only once it has lost STARVE_LIM grants in a row.
   assign ls_wins = ls_req_valid && !(if_req_valid && (starve_cnt_q == LIM));

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      starve_cnt_d  = starve_cnt_q;
      addr_d        = addr_q;
      wen_d         = wen_q;
      wdata_d       = wdata_q;
      wmask_d       = wmask_q;
      if_req_ready  = 1'b0;
      ls_req_ready  = 1'b0;
      mem_req_valid = 1'b0;
      if_rsp_valid  = 1'b0;
      ls_rsp_valid  = 1'b0;

      // Handshakes are suppressed while reset is held so outputs read 0 then.
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (if_req_valid || ls_req_valid) begin
                  state_d = REQ;
                  if (ls_wins) begin
                     ls_req_ready = 1'b1;
                     owner_d      = OWN_LS;
                     addr_d       = ls_addr;
                     wen_d        = ls_wen;
                     wdata_d      = ls_wdata;
                     wmask_d      = ls_wmask;
                     if (if_req_valid && (starve_cnt_q < LIM)) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                     end
                  end else begin
                     if_req_ready = 1'b1;
                     owner_d      = OWN_IF;
                     addr_d       = if_addr;
                     wen_d        = 1'b0;
                     wdata_d      = '0;
                     wmask_d      = '0;
                     starve_cnt_d = 4'd0;
                  end
               end
            end
            REQ: begin
               mem_req_valid = 1'b1;
               if (mem_req_ready) begin
                  state_d = WAIT;
               end
            end
            WAIT: begin
               if (mem_rsp_valid) begin
                  state_d      = IDLE;
                  if_rsp_valid = (owner_q == OWN_IF);
                  ls_rsp_valid = (owner_q == OWN_LS);
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= OWN_IF;
         starve_cnt_q <= 4'd0;
         addr_q       <= '0;
         wen_q        <= 1'b0;
         wdata_q      <= '0;
         wmask_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         starve_cnt_q <= starve_cnt_d;
         addr_q       <= addr_d;
         wen_q        <= wen_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wen   = wen_q;
   assign mem_wdata = wdata_q;
   assign mem_wmask = wmask_q;
   assign if_rdata  = if_rsp_valid ? mem_rdata : '0;
   assign ls_rdata  = ls_rsp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic, checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

   localparam int AW  = 64;
   localparam int DW  = 64;
   localparam int MW  = DW / 8;
   localparam int LIM = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req_valid, if_req_ready, if_rsp_valid;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid;
   logic [AW-1:0] ls_addr;
   logic [DW-1:0] ls_wdata, ls_rdata;
   logic [MW-1:0] ls_wmask;
   logic          mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [MW-1:0] mem_wmask;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
      .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
      .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
      .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
      .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: IF loss count plus the payload the memory side should show.
   int            starve = 0;
   logic [AW-1:0] last_addr  = '0;
   logic          last_wen   = 1'b0;
   logic [DW-1:0] last_wdata = '0;
   logic [MW-1:0] last_wmask = '0;
   bit            got_ls;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_payload(input string tag);
      chk({tag, "_addr"},  mem_addr,  last_addr);
      chk({tag, "_wen"},   mem_wen,   last_wen);
      chk({tag, "_wdata"}, mem_wdata, last_wdata);
      chk({tag, "_wmask"}, mem_wmask, last_wmask);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_if_rsp"}, if_rsp_valid, 1'b0);
      chk({tag, "_ls_rsp"}, ls_rsp_valid, 1'b0);
      chk({tag, "_if_rdata"}, if_rdata, '0);
      chk({tag, "_ls_rdata"}, ls_rdata, '0);
   endtask

   // One complete transaction starting in IDLE with the current request inputs.
   task automatic do_txn(input int rdy_dly, input int rsp_dly, input logic [DW-1:0] rdata,
                         output bit ls_won);
      bit ls_win, fire;
      mem_rsp_valid = 1'($urandom_range(0, 1));
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_rdata     = {$urandom, $urandom};
      #1;
      ls_win = ls_req_valid && !(if_req_valid && starve == LIM);
      chk("grant_if_ready", if_req_ready, !ls_win && if_req_valid);
      chk("grant_ls_ready", ls_req_ready, ls_win);
      chk("grant_mem_valid", mem_req_valid, 1'b0);
      chk_quiet("grant");
      chk_payload("idle_hold");
      if (ls_win) begin
         if (if_req_valid && starve < LIM) starve++;
         last_addr = ls_addr; last_wen = ls_wen; last_wdata = ls_wdata; last_wmask = ls_wmask;
      end else begin
         starve = 0;
         last_addr = if_addr; last_wen = 1'b0; last_wdata = '0; last_wmask = '0;
      end
      ls_won = ls_win;
      tick();
      if (ls_win) ls_req_valid = 1'b0; else if_req_valid = 1'b0;
      for (int d = 0; d <= rdy_dly; d++) begin
         mem_req_ready = (d == rdy_dly);
         mem_rsp_valid = 1'($urandom_range(0, 1));
         mem_rdata     = {$urandom, $urandom};
         #1;
         chk("req_mem_valid", mem_req_valid, 1'b1);
         chk("req_if_ready", if_req_ready, 1'b0);
         chk("req_ls_ready", ls_req_ready, 1'b0);
         chk_payload("req");
         chk_quiet("req");
         tick();
      end
      for (int d = 0; d <= rsp_dly; d++) begin
         fire          = (d == rsp_dly);
         mem_req_ready = 1'($urandom_range(0, 1));
         mem_rsp_valid = fire;
         mem_rdata     = fire ? rdata : {$urandom, $urandom};
         #1;
         chk("wait_mem_valid", mem_req_valid, 1'b0);
         chk("wait_if_ready", if_req_ready, 1'b0);
         chk("wait_ls_ready", ls_req_ready, 1'b0);
         chk("wait_if_rsp", if_rsp_valid, fire && !ls_win);
         chk("wait_ls_rsp", ls_rsp_valid, fire && ls_win);
         chk("wait_if_rdata", if_rdata, (fire && !ls_win) ? rdata : '0);
         chk("wait_ls_rdata", ls_rdata, (fire && ls_win) ? rdata : '0);
         tick();
      end
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_valid"}, mem_req_valid, 1'b0);
      chk({tag, "_if_ready"}, if_req_ready, 1'b0);
      chk({tag, "_ls_ready"}, ls_req_ready, 1'b0);
      chk({tag, "_mem_addr"}, mem_addr, '0);
      chk({tag, "_mem_wen"}, mem_wen, 1'b0);
      chk({tag, "_mem_wdata"}, mem_wdata, '0);
      chk({tag, "_mem_wmask"}, mem_wmask, '0);
      chk_quiet(tag);
   endtask

   initial begin
      bit order[6];
      rst = 1'b1;
      if_req_valid = 0; if_addr = '0;
      ls_req_valid = 0; ls_addr = '0; ls_wen = 0; ls_wdata = '0; ls_wmask = '0;
      mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
      tick(); tick();
      mem_rsp_valid = 1'b1; mem_rdata = 64'hFFFF;
      #1;
      chk_all_zero("reset");
      rst = 1'b0;
      mem_rsp_valid = 1'b0;
      tick();

      // Lone fetch at minimum latency.
      if_req_valid = 1'b1; if_addr = 64'h8000_0000;
      do_txn(0, 0, 64'h13, got_ls);
      chk("lone_fetch_owner", got_ls, 1'b0);

      // Tie: LS first, IF only after the LS response.
      if_req_valid = 1'b1; if_addr = 64'h8000_0040;
      ls_req_valid = 1'b1; ls_addr = 64'h8000_2000; ls_wen = 1'b0;
      do_txn(1, 1, 64'h1111, got_ls);
      chk("tie_first_owner", got_ls, 1'b1);
      do_txn(0, 2, 64'h2222, got_ls);
      chk("tie_second_owner", got_ls, 1'b0);

      // Starvation: both held valid continuously.
      for (int i = 0; i < 6; i++) begin
         if_req_valid = 1'b1; if_addr = 64'h8000_0100 + 64'(i * 4);
         ls_req_valid = 1'b1; ls_addr = 64'h8000_3000 + 64'(i * 8);
         do_txn(0, 0, 64'(i + 100), got_ls);
         order[i] = got_ls;
      end
      chk("starve_order", {order[0], order[1], order[2], order[3], order[4], order[5]},
          6'b110110);
      if_req_valid = 1'b0;

      // Store with the memory stalling the request for three cycles.
      ls_req_valid = 1'b1; ls_addr = 64'h8000_1000; ls_wen = 1'b1;
      ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
      do_txn(3, 1, 64'h0, got_ls);
      chk("store_owner", got_ls, 1'b1);
      ls_wen = 1'b0;

      // Stray response in IDLE.
      mem_rsp_valid = 1'b1; mem_rdata = 64'hABCD;
      #1;
      chk_quiet("stray");
      chk("stray_mem_valid", mem_req_valid, 1'b0);
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      chk("stray_stays_idle", mem_req_valid, 1'b0);
      tick();

      // Reset while waiting for a response; the late response is ignored.
      ls_req_valid = 1'b1; ls_addr = 64'h8000_4000;
      tick();
      ls_req_valid = 1'b0; mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0; rst = 1'b1;
      #1;
      chk("rst_wait_mem_valid", mem_req_valid, 1'b0);
      tick();
      rst = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'h5555;
      starve = 0; last_addr = '0; last_wen = 0; last_wdata = '0; last_wmask = '0;
      #1;
      chk_all_zero("post_rst");
      tick();
      mem_rsp_valid = 1'b0;

      // Randomized traffic honouring the hold-until-ready protocol.
      for (int t = 0; t < 60; t++) begin
         if (!if_req_valid && $urandom_range(0, 1) == 1) begin
            if_req_valid = 1'b1; if_addr = {$urandom, $urandom};
         end
         if (!ls_req_valid && $urandom_range(0, 1) == 1) begin
            ls_req_valid = 1'b1; ls_addr = {$urandom, $urandom};
            ls_wen = 1'($urandom_range(0, 1)); ls_wdata = {$urandom, $urandom};
            ls_wmask = 8'($urandom);
         end
         if (!if_req_valid && !ls_req_valid) begin
            if_req_valid = 1'b1; if_addr = {$urandom, $urandom};
         end
         do_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                {$urandom, $urandom}, got_ls);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single memory port between instruction fetch (IF) and the load/store unit (LS). It holds at most one outstanding transaction, registers the granted request, and routes the memory response back to its owner. It sits between the fetch/LSU logic of `top` and the simulation memory (DPI-backed) bus. Arbitration is fixed-priority (LS first) with a starvation guard for IF.

## Interface
- `ADDR_W`, default 64: address width
- `DATA_W`, default 64: data width
- `STARVE_LIM`, default 2: consecutive IF losses after which IF wins a tie; legal range 1..15

- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `if_req_valid`  in  1  fetch request
- `if_req_ready`  out  1  fetch request accepted this cycle
- `if_addr`  in  ADDR_W  fetch address
- `if_rsp_valid`  out  1  fetch data valid, one-cycle pulse
- `if_rdata`  out  DATA_W  fetch data
- `ls_req_valid`  in  1  LSU request
- `ls_req_ready`  out  1  LSU request accepted this cycle
- `ls_addr`  in  ADDR_W  LSU address
- `ls_wen`  in  1  1 = store, 0 = load
- `ls_wdata`  in  DATA_W  store data
- `ls_wmask`  in  DATA_W/8  store byte mask
- `ls_rsp_valid`  out  1  LSU response pulse; for stores it is a write acknowledge
- `ls_rdata`  out  DATA_W  load data
- `mem_req_valid`  out  1  memory request
- `mem_req_ready`  in  1  memory accepts the request
- `mem_addr`, `mem_wen`, `mem_wdata`, `mem_wmask`  out  ADDR_W / 1 / DATA_W / DATA_W/8  registered request payload
- `mem_rsp_valid`  in  1  memory response
- `mem_rdata`  in  DATA_W  memory read data

## Operation
The arbiter is a three-state FSM: IDLE, REQ, WAIT.

- **IDLE**
  - If any request is valid, pick the owner:
    - LS wins if `ls_req_valid` and not (`if_req_valid` and `starve_cnt == STARVE_LIM`).
    - Otherwise IF wins.
  - Assert the winner's `*_req_ready` combinationally in that cycle.
  - Latch the winner's payload and owner into holding registers; go to REQ.
  - For an IF grant, drive `mem_wen = 0` and `mem_wmask = 0`.
- **REQ**
  - `mem_req_valid = 1` with the registered payload; the payload stays stable until `mem_req_ready`.
  - On `mem_req_ready`, go to WAIT.
- **WAIT**
  - On `mem_rsp_valid`, assert the owner's `*_rsp_valid` combinationally in the same cycle, with `*_rdata = mem_rdata`; go to IDLE.
- `*_req_ready` is only ever asserted in IDLE, so a new grant is possible at the earliest one cycle after a response.
- Masters hold `valid` and payload stable until `ready`; the arbiter never retracts a grant.
- **Starvation counter** (4-bit `starve_cnt`):
  - Increments, saturating at `STARVE_LIM`, when LS is granted while `if_req_valid = 1`.
  - Clears when IF is granted.
  - Otherwise holds.
- **Ignored events**
  - `mem_rsp_valid` outside WAIT is ignored; no response pulse is generated.
  - `mem_req_ready` outside REQ is ignored.
- **Output values outside the active states**
  - `*_rdata` equals `mem_rdata` only while that master's `rsp_valid` is high; otherwise it is 0.
  - `mem_*` payload outputs equal the holding registers in every state.

## Timing
- **Reset:** state = IDLE, `starve_cnt` = 0, holding registers = 0. All outputs are 0: `mem_req_valid`, `if/ls_req_ready`, `if/ls_rsp_valid`, `mem_addr`, `mem_wen`, `mem_wdata`, `mem_wmask`, `if_rdata`, `ls_rdata`.
- **Reset mid-transaction:** the transaction is dropped and the FSM returns to IDLE the following cycle. The memory model is reset in the same cycle by the system.
- **Minimum latency** (memory ready immediately, response the next cycle):
  - cycle 0: grant
  - cycle 1: `mem_req_valid` handshake
  - cycle 2: `rsp_valid`
  - cycle 3: next grant possible
- **Throughput:** at most one transaction per three cycles.
- **Simultaneous request and response for the same master:** if a master raises `req_valid` in the same cycle it receives `rsp_valid`, that request is seen next cycle in IDLE. There is no bypass.

## Structure
- Shared package `npc_mem_pkg`:
  - `owner_e` (OWN_IF, OWN_LS)
  - `arb_state_e` (IDLE, REQ, WAIT)
  - `ADDR_W` / `DATA_W` defaults
- Single module; no sub-module. The FSM, holding registers and starvation counter are inline.

## Test plan
- **Lone fetch:** `if_req_valid = 1`, `if_addr = 0x80000000`, memory ready at once, responds `0x00000013` next cycle → `if_req_ready` in cycle 0, `mem_addr = 0x80000000` with `mem_wen = 0` in cycle 1, `if_rsp_valid` with `if_rdata = 0x13` in cycle 2.
- **Tie:** both valid with `starve_cnt = 0` → LS granted first, `starve_cnt = 1`; IF is granted only after the LS response.
- **Starvation:** with `STARVE_LIM = 2`, IF and LS both held valid continuously → grant order LS, LS, IF, LS, LS, IF; `starve_cnt` reads 0 after each IF grant.
- **Store:** `ls_wen = 1`, `addr = 0x80001000`, `wdata = 0xDEADBEEF`, `wmask = 0x0F`, memory holds `mem_req_ready` low for 3 cycles → payload stable for all 3 cycles; `ls_rsp_valid` pulses once after the ack.
- **Stray response and reset:** `mem_rsp_valid` asserted in IDLE → no `rsp_valid` pulse. `rst` asserted in WAIT → next cycle IDLE, all outputs 0, and the late response is ignored.
